// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between the fetch (imem)
// and data (dmem) ports. Requests are latched into pending slots, one
// transaction is issued at a time with fixed priority, and responses are
// routed to whichever port owns the outstanding transaction.
module mem_arbiter #(
  parameter bit IMEM_PRIORITY = 1'b0  // 0: dmem wins ties, 1: imem wins ties
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      r_state;

  // Pending slots: hold a request that could not be issued at the next edge.
  logic        r_ip_v;
  logic [31:0] r_ip_addr;
  logic [3:0]  r_ip_rmask;
  logic        r_dp_v;
  logic [31:0] r_dp_addr;
  logic [3:0]  r_dp_rmask;
  logic [3:0]  r_dp_wmask;
  logic [31:0] r_dp_wdata;

  logic        w_i_new, w_d_new;
  logic        w_i_cand, w_d_cand;
  logic        w_free, w_pick_i, w_pick_d;
  logic [31:0] w_i_addr, w_d_addr, w_d_wdata;
  logic [3:0]  w_i_rmask, w_d_rmask, w_d_wmask;

  assign w_i_new  = |imem_rmask;
  assign w_d_new  = (|dmem_rmask) | (|dmem_wmask);
  assign w_i_cand = r_ip_v | w_i_new;
  assign w_d_cand = r_dp_v | w_d_new;

  // A pending entry takes precedence over the live inputs; the requester
  // protocol guarantees the two never coexist on the same port.
  assign w_i_addr  = r_ip_v ? r_ip_addr  : imem_addr;
  assign w_i_rmask = r_ip_v ? r_ip_rmask : imem_rmask;
  assign w_d_addr  = r_dp_v ? r_dp_addr  : dmem_addr;
  assign w_d_rmask = r_dp_v ? r_dp_rmask : dmem_rmask;
  assign w_d_wmask = r_dp_v ? r_dp_wmask : dmem_wmask;
  assign w_d_wdata = r_dp_v ? r_dp_wdata : dmem_wdata;

  // The unified port can accept a new issue when idle or when the
  // outstanding transaction completes this cycle.
  assign w_free   = (r_state == IDLE) | mem_resp;
  assign w_pick_d = w_d_cand & (~w_i_cand | (IMEM_PRIORITY == 1'b0));
  assign w_pick_i = w_i_cand & ~w_pick_d;

  // Responses are forwarded with zero added latency to the owning port.
  assign imem_resp  = mem_resp & (r_state == BUSY_I);
  assign dmem_resp  = mem_resp & (r_state == BUSY_D);
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  // Arbitration FSM with registered mem_* outputs; masks pulse for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      mem_addr  <= '0;
      mem_rmask <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      mem_rmask <= '0;
      mem_wmask <= '0;
      if (w_free) begin
        if (w_pick_d) begin
          mem_addr  <= w_d_addr;
          mem_rmask <= w_d_rmask;
          mem_wmask <= w_d_wmask;
          mem_wdata <= w_d_wdata;
          r_state   <= BUSY_D;
        end else if (w_pick_i) begin
          mem_addr  <= w_i_addr;
          mem_rmask <= w_i_rmask;
          r_state   <= BUSY_I;
        end else begin
          r_state   <= IDLE;
        end
      end
    end
  end

  // Pending slots: set on any candidate that does not win issue this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ip_v     <= 1'b0;
      r_ip_addr  <= '0;
      r_ip_rmask <= '0;
      r_dp_v     <= 1'b0;
      r_dp_addr  <= '0;
      r_dp_rmask <= '0;
      r_dp_wmask <= '0;
      r_dp_wdata <= '0;
    end else begin
      r_ip_v <= w_i_cand & ~(w_free & w_pick_i);
      r_dp_v <= w_d_cand & ~(w_free & w_pick_d);
      if (w_i_new && !r_ip_v) begin
        r_ip_addr  <= imem_addr;
        r_ip_rmask <= imem_rmask;
      end
      if (w_d_new && !r_dp_v) begin
        r_dp_addr  <= dmem_addr;
        r_dp_rmask <= dmem_rmask;
        r_dp_wmask <= dmem_wmask;
        r_dp_wdata <= dmem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share all inputs: dut0 uses
// dmem priority, dut1 imem priority. Inputs change 1ns after each rising
// edge, outputs are sampled 2ns after it.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        mem_resp;

  logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0;
  logic        i_resp0, d_resp0;
  logic [3:0]  m_rmask0, m_wmask0;
  logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        i_resp1, d_resp1;
  logic [3:0]  m_rmask1, m_wmask1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.IMEM_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(i_rdata0), .imem_resp(i_resp0),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(d_rdata0), .dmem_resp(d_resp0),
    .mem_addr(m_addr0), .mem_rmask(m_rmask0), .mem_wmask(m_wmask0),
    .mem_wdata(m_wdata0), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_arbiter #(.IMEM_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(i_rdata1), .imem_resp(i_resp1),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(d_rdata1), .dmem_resp(d_resp1),
    .mem_addr(m_addr1), .mem_rmask(m_rmask1), .mem_wmask(m_wmask1),
    .mem_wdata(m_wdata1), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Advance to the next cycle: inputs may be driven right after return.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_addr  = '0; imem_rmask = '0;
    dmem_addr  = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
    mem_resp   = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    mem_resp = 1'b1;
    #2;
    n_chk++; if ({m_addr0, m_rmask0, m_wmask0, m_wdata0} !== 72'h0) begin n_fail++;
      $display("FAIL reset_mem_outputs got %h %h %h %h want 0", m_addr0, m_rmask0, m_wmask0, m_wdata0); end
    n_chk++; if ({i_resp0, d_resp0, i_resp1, d_resp1} !== 4'b0) begin n_fail++;
      $display("FAIL reset_resp got %b want 0000", {i_resp0, d_resp0, i_resp1, d_resp1}); end
    next_cycle();
    mem_resp = 1'b0;
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_fetch();
    imem_rmask = 4'hF; imem_addr = 32'h1eceb000;        // T
    #1;
    n_chk++; if (m_rmask0 !== 4'h0) begin n_fail++;
      $display("FAIL fetch_no_issue_T got %h want 0", m_rmask0); end
    next_cycle(); imem_rmask = '0; imem_addr = '0;      // T+1
    #1;
    n_chk++; if (m_rmask0 !== 4'hF || m_addr0 !== 32'h1eceb000) begin n_fail++;
      $display("FAIL fetch_issue got %h/%h want f/1eceb000", m_rmask0, m_addr0); end
    next_cycle();                                       // T+2
    #1;
    n_chk++; if (m_rmask0 !== 4'h0 || i_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL fetch_one_pulse got %h resp %b want 0/0", m_rmask0, i_resp0); end
    next_cycle(); mem_resp = 1'b1; mem_rdata = 32'h00000013;  // T+3
    #1;
    n_chk++; if (i_resp0 !== 1'b1 || i_rdata0 !== 32'h00000013 || d_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL fetch_resp got resp %b data %h dresp %b want 1/00000013/0", i_resp0, i_rdata0, d_resp0); end
    next_cycle(); mem_resp = 1'b0;                      // T+4
    #1;
    n_chk++; if (i_resp0 !== 1'b0 || m_rmask0 !== 4'h0) begin n_fail++;
      $display("FAIL fetch_done got resp %b rmask %h want 0/0", i_resp0, m_rmask0); end
  endtask

  task automatic test_contention();
    imem_rmask = 4'hF; imem_addr = 32'h100;             // T
    dmem_wmask = 4'hF; dmem_addr = 32'h200; dmem_wdata = 32'hDEADBEEF;
    next_cycle(); clear_inputs();                       // T+1
    #1;
    n_chk++; if (m_wmask0 !== 4'hF || m_rmask0 !== 4'h0 || m_addr0 !== 32'h200 || m_wdata0 !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL cont_p0_first got w%h r%h a%h d%h want f/0/200/deadbeef", m_wmask0, m_rmask0, m_addr0, m_wdata0); end
    n_chk++; if (m_rmask1 !== 4'hF || m_wmask1 !== 4'h0 || m_addr1 !== 32'h100) begin n_fail++;
      $display("FAIL cont_p1_first got r%h w%h a%h want f/0/100", m_rmask1, m_wmask1, m_addr1); end
    next_cycle(); mem_resp = 1'b1; mem_rdata = 32'h55;  // T+2
    #1;
    n_chk++; if (d_resp0 !== 1'b1 || i_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL cont_p0_dresp got d%b i%b want 1/0", d_resp0, i_resp0); end
    n_chk++; if (i_resp1 !== 1'b1 || d_resp1 !== 1'b0 || i_rdata1 !== 32'h55) begin n_fail++;
      $display("FAIL cont_p1_iresp got i%b d%b data %h want 1/0/55", i_resp1, d_resp1, i_rdata1); end
    next_cycle(); mem_resp = 1'b0;                      // T+3
    #1;
    n_chk++; if (m_rmask0 !== 4'hF || m_wmask0 !== 4'h0 || m_addr0 !== 32'h100) begin n_fail++;
      $display("FAIL cont_p0_second got r%h w%h a%h want f/0/100", m_rmask0, m_wmask0, m_addr0); end
    n_chk++; if (m_wmask1 !== 4'hF || m_addr1 !== 32'h200 || m_wdata1 !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL cont_p1_second got w%h a%h d%h want f/200/deadbeef", m_wmask1, m_addr1, m_wdata1); end
    next_cycle(); mem_resp = 1'b1;                      // T+4
    #1;
    n_chk++; if (i_resp0 !== 1'b1 || d_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL cont_p0_iresp got i%b d%b want 1/0", i_resp0, d_resp0); end
    n_chk++; if (d_resp1 !== 1'b1 || i_resp1 !== 1'b0) begin n_fail++;
      $display("FAIL cont_p1_dresp got d%b i%b want 1/0", d_resp1, i_resp1); end
    next_cycle(); mem_resp = 1'b0;                      // T+5
    #1;
    n_chk++; if ({m_rmask0, m_wmask0, m_rmask1, m_wmask1} !== 16'h0) begin n_fail++;
      $display("FAIL cont_quiet got %h want 0", {m_rmask0, m_wmask0, m_rmask1, m_wmask1}); end
  endtask

  task automatic test_back_to_back();
    imem_rmask = 4'hF; imem_addr = 32'h140;             // T
    next_cycle(); clear_inputs();                       // T+1: fetch issued
    dmem_rmask = 4'hF; dmem_addr = 32'h300;             // goes pending
    #1;
    n_chk++; if (m_rmask0 !== 4'hF || m_addr0 !== 32'h140) begin n_fail++;
      $display("FAIL b2b_fetch got %h/%h want f/140", m_rmask0, m_addr0); end
    next_cycle(); clear_inputs(); mem_resp = 1'b1;      // T+2
    #1;
    n_chk++; if (i_resp0 !== 1'b1 || m_rmask0 !== 4'h0) begin n_fail++;
      $display("FAIL b2b_iresp got i%b r%h want 1/0", i_resp0, m_rmask0); end
    next_cycle(); mem_resp = 1'b0;                      // T+3
    #1;
    n_chk++; if (m_rmask0 !== 4'hF || m_addr0 !== 32'h300) begin n_fail++;
      $display("FAIL b2b_no_bubble got %h/%h want f/300", m_rmask0, m_addr0); end
    next_cycle(); mem_resp = 1'b1; mem_rdata = 32'hA5A5A5A5;  // T+4
    #1;
    n_chk++; if (d_resp0 !== 1'b1 || d_rdata0 !== 32'hA5A5A5A5 || i_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL b2b_dresp got d%b data %h i%b want 1/a5a5a5a5/0", d_resp0, d_rdata0, i_resp0); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    dmem_rmask = 4'hF; dmem_addr = 32'h400;             // T
    next_cycle(); clear_inputs();                       // T+1 issued
    #1;
    n_chk++; if (m_rmask0 !== 4'hF || m_addr0 !== 32'h400) begin n_fail++;
      $display("FAIL rmid_issue got %h/%h want f/400", m_rmask0, m_addr0); end
    next_cycle(); rst = 1'b0; mem_resp = 1'b1;          // T+2 reset with resp
    #1;
    n_chk++; if ({m_addr0, m_rmask0, m_wmask0, m_wdata0} !== 72'h0 || d_resp0 !== 1'b0 || i_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL rmid_in_reset got a%h r%h d%b want 0/0/0", m_addr0, m_rmask0, d_resp0); end
    next_cycle(); rst = 1'b1; mem_resp = 1'b1;          // T+3 stray resp
    #1;
    n_chk++; if (d_resp0 !== 1'b0 || i_resp0 !== 1'b0 || d_resp1 !== 1'b0) begin n_fail++;
      $display("FAIL rmid_stray_resp got d%b i%b want 0/0", d_resp0, i_resp0); end
    next_cycle(); mem_resp = 1'b0; imem_rmask = 4'hF; imem_addr = 32'h500;  // T+4
    #1;
    n_chk++; if (m_rmask0 !== 4'h0) begin n_fail++;
      $display("FAIL rmid_idle got %h want 0", m_rmask0); end
    next_cycle(); clear_inputs();                       // T+5
    #1;
    n_chk++; if (m_rmask0 !== 4'hF || m_addr0 !== 32'h500) begin n_fail++;
      $display("FAIL rmid_new_fetch got %h/%h want f/500", m_rmask0, m_addr0); end
    next_cycle(); mem_resp = 1'b1;                      // T+6
    #1;
    n_chk++; if (i_resp0 !== 1'b1 || d_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL rmid_fetch_resp got i%b d%b want 1/0", i_resp0, d_resp0); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_req_with_resp();
    dmem_rmask = 4'hF; dmem_addr = 32'h600;             // T
    next_cycle(); clear_inputs();                       // T+1
    next_cycle(); mem_resp = 1'b1;                      // T+2: resp + new fetch
    imem_rmask = 4'hF; imem_addr = 32'h700;
    #1;
    n_chk++; if (d_resp0 !== 1'b1 || i_resp0 !== 1'b0) begin n_fail++;
      $display("FAIL rwr_dresp got d%b i%b want 1/0", d_resp0, i_resp0); end
    next_cycle(); clear_inputs();                       // T+3
    #1;
    n_chk++; if (m_rmask0 !== 4'hF || m_addr0 !== 32'h700 || m_wmask0 !== 4'h0) begin n_fail++;
      $display("FAIL rwr_fetch_next got r%h a%h w%h want f/700/0", m_rmask0, m_addr0, m_wmask0); end
    next_cycle(); mem_resp = 1'b1;                      // T+4
    #1;
    n_chk++; if (i_resp0 !== 1'b1) begin n_fail++;
      $display("FAIL rwr_iresp got %b want 1", i_resp0); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_rw_combined();
    dmem_rmask = 4'h3; dmem_wmask = 4'hC; dmem_addr = 32'h800; dmem_wdata = 32'h12345678;
    next_cycle(); clear_inputs();
    #1;
    n_chk++; if (m_rmask0 !== 4'h3 || m_wmask0 !== 4'hC || m_wdata0 !== 32'h12345678) begin n_fail++;
      $display("FAIL rw_masks got r%h w%h d%h want 3/c/12345678", m_rmask0, m_wmask0, m_wdata0); end
    next_cycle(); mem_resp = 1'b1;
    #1;
    n_chk++; if (d_resp0 !== 1'b1) begin n_fail++;
      $display("FAIL rw_resp got %b want 1", d_resp0); end
    next_cycle(); mem_resp = 1'b0;
    #1;
    n_chk++; if (m_rmask0 !== 4'h0 || m_wmask0 !== 4'h0) begin n_fail++;
      $display("FAIL rw_single_txn got r%h w%h want 0/0", m_rmask0, m_wmask0); end
  endtask

  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    next_cycle();
    test_contention();
    next_cycle();
    test_back_to_back();
    test_reset_mid();
    test_req_with_resp();
    test_rw_combined();
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one multi-cycle memory port between the pipeline's instruction-fetch port (imem) and data port (dmem). Each side sees the same rmask/wmask/resp protocol the cpu already uses. Requests are latched, arbitrated with a fixed priority, and issued one at a time onto the unified port. Responses are routed back to the requester that owns the outstanding transaction. The block sits between `cpu` and the single-ported memory model / cache, replacing the two independent memory ports.

## Interface
Parameters:
- IMEM_PRIORITY, 0, 0: dmem wins simultaneous contention; 1: imem wins.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_addr  in  32  fetch address, valid when imem_rmask != 0
- imem_rmask  in  4  fetch read mask; nonzero for one cycle = request
- imem_rdata  out  32  fetch read data, valid with imem_resp
- imem_resp  out  1  one-cycle fetch completion
- dmem_addr  in  32  data address
- dmem_rmask  in  4  data read mask; nonzero for one cycle = read request
- dmem_wmask  in  4  data write mask; nonzero for one cycle = write request
- dmem_wdata  in  32  write data, valid with dmem_wmask
- dmem_rdata  out  32  data read data, valid with dmem_resp
- dmem_resp  out  1  one-cycle data completion (reads and writes)
- mem_addr  out  32  unified port address
- mem_rmask  out  4  unified read mask, one-cycle pulse per issue
- mem_wmask  out  4  unified write mask, one-cycle pulse per issue
- mem_wdata  out  32  unified write data
- mem_rdata  in  32  unified read data, valid with mem_resp
- mem_resp  in  1  unified completion, at least 1 cycle after issue

## Operation
- A request is any cycle in which the port's mask(s) are nonzero.
- The requester presents a request once and issues no new request on that port until its resp.
- State machine: IDLE, BUSY_I, BUSY_D.
- Pending registers: one per port, each holding {valid, addr, masks, wdata}. They capture a request that cannot be issued at the next edge.
- Issue rule, evaluated each edge when state is IDLE, or when state is BUSY and mem_resp is high:
  - Candidates are the pending entries plus requests arriving this cycle.
  - If both ports are candidates, the winner is set by IMEM_PRIORITY.
  - The winner's fields load into the mem_* output registers, the state becomes BUSY_I or BUSY_D, and the winner's pending entry is cleared.
  - The loser is written or kept in its pending register.
  - If there are no candidates, the state becomes IDLE.
- In BUSY with mem_resp low:
  - Arriving requests go to their pending registers.
  - mem_rmask and mem_wmask are 0.
  - mem_addr and mem_wdata hold their value.
- Response routing (combinational):
  - imem_resp = mem_resp & (state == BUSY_I).
  - dmem_resp = mem_resp & (state == BUSY_D).
  - imem_rdata and dmem_rdata are both driven by mem_rdata, which is don't-care when resp is low.
- mem_resp while IDLE is ignored: no resp is forwarded and state is unchanged.
- dmem request with both rmask and wmask nonzero: both masks are forwarded unchanged, and it counts as a single transaction.

## Timing
- On reset assert (asynchronous):
  - State becomes IDLE and both pending valids clear.
  - mem_addr, mem_rmask, mem_wmask and mem_wdata become 0.
  - imem_resp and dmem_resp become 0.
- Issue latency: a request arriving in cycle T with the arbiter free is issued on mem_* in cycle T+1, for exactly one cycle.
- Return latency: zero added. Requester resp and rdata appear in the same cycle as mem_resp.
- Minimum request-to-resp time is 2 cycles when memory responds 1 cycle after issue.
- Back-to-back: the next transaction issues in the cycle after mem_resp, so there are no idle bubbles when work is pending.
- Simultaneous mem_resp and a new request on the other port (or the same port) in cycle T: the new request is a candidate and issues in T+1.
- Reset mid-transaction: the outstanding transaction is dropped and no resp is forwarded. A late mem_resp arriving after reset release is ignored (state is IDLE).
- Throughput bound: at most one outstanding memory transaction.

## Test plan
- Single fetch: imem_rmask=4'hF and addr=0x1eceb000 at T; memory responds at T+3 with 0x00000013. Required: mem_rmask=4'hF and mem_addr=0x1eceb000 only at T+1; imem_resp=1 and imem_rdata=0x00000013 at T+3; dmem_resp stays 0.
- Contention, IMEM_PRIORITY=0: imem read of 0x100 and dmem write of 0x200 (wdata 0xDEADBEEF, wmask 4'hF) at the same T. Required: the write issues at T+1; the fetch issues in the cycle after dmem_resp; imem_resp follows the fetch's mem_resp.
- Same stimulus with IMEM_PRIORITY=1: the fetch issues first at T+1 and the write second.
- Back-to-back: dmem read pending while an imem transaction completes. Required: mem_rmask pulse in the cycle immediately after mem_resp, with no idle cycle.
- Reset mid-operation: assert rst low with BUSY_D outstanding, release, then drive a stray mem_resp. Required: all outputs 0 during reset, no dmem_resp, state IDLE. A subsequent imem request issues normally.
- Request coinciding with response: imem request in the same cycle as mem_resp for dmem. Required: dmem_resp that cycle, and the fetch issued the next cycle.
